// File: rtl/serial_subtractor_if.sv
// Handshake and operand bus between a requester and the bit-serial subtractor.
// The requester drives the operands and start; the subtractor returns busy,
// done and the registered result.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             borrow_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] diff_o;
   logic             borrow_o;

   modport master (
      output start_i, a_i, b_i, borrow_i,
      input  busy_o, done_o, diff_o, borrow_o
   );

   modport slave (
      input  start_i, a_i, b_i, borrow_i,
      output busy_o, done_o, diff_o, borrow_o
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: latches two operands, walks them LSB-first through a
// 1-bit full subtractor cell, carries the borrow between bits in a register
// and assembles the difference word. Result is a - b - borrow_in mod 2^WIDTH.

// 1-bit full subtractor cell: diff = a - b - c, borrow out when a < b + c.
module full_subtractor (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic borrow_o,
   output logic diff_o
);
   assign diff_o   = a_i ^ b_i ^ c_i;
   assign borrow_o = (~a_i & b_i) | (~a_i & c_i) | (b_i & c_i);
endmodule

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   serial_subtractor_if.slave   bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_out_q, borrow_out_d;

   logic             cell_borrow;
   logic             cell_diff;

   // The cell always sees the current low bits and the carried borrow; its
   // outputs are only consumed while running.
   full_subtractor u_cell (
      .a_i      (a_sh_q[0]),
      .b_i      (b_sh_q[0]),
      .c_i      (borrow_q),
      .borrow_o (cell_borrow),
      .diff_o   (cell_diff)
   );

   // Next-state logic: accept in IDLE/DONE, one bit per edge in RUN, and
   // publish the finished word on the last bit. Outputs derive from the next
   // state so they come straight out of flops.
   always_comb begin
      state_d      = state_q;
      a_sh_d       = a_sh_q;
      b_sh_d       = b_sh_q;
      work_d       = work_q;
      borrow_d     = borrow_q;
      cnt_d        = cnt_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;

      case (state_q)
         RUN: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            work_d   = {cell_diff, work_q[WIDTH-1:1]};
            borrow_d = cell_borrow;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               diff_d       = {cell_diff, work_q[WIDTH-1:1]};
               borrow_out_d = cell_borrow;
               state_d      = DONE;
            end
         end
         default: begin
            if (bus.start_i) begin
               a_sh_d   = bus.a_i;
               b_sh_d   = bus.b_i;
               borrow_d = bus.borrow_i;
               cnt_d    = '0;
               state_d  = RUN;
            end else begin
               state_d  = IDLE;
            end
         end
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // All sequencing state and the registered outputs, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         a_sh_q       <= '0;
         b_sh_q       <= '0;
         work_q       <= '0;
         borrow_q     <= 1'b0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_sh_q       <= a_sh_d;
         b_sh_q       <= b_sh_d;
         work_q       <= work_d;
         borrow_q     <= borrow_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
      end
   end

   assign bus.busy_o   = busy_q;
   assign bus.done_o   = done_q;
   assign bus.diff_o   = diff_q;
   assign bus.borrow_o = borrow_out_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for the bit-serial subtractor: handshake timing, corner
// operands, ignored mid-run start, back-to-back, mid-run reset, and an
// exhaustive sweep of a 4-bit instance against a subtraction model.
module tb_serial_subtractor;
   logic clk_i;
   logic rst_n_i;
   int   checks;
   int   errors;

   serial_subtractor_if #(.WIDTH(8)) if8 ();
   serial_subtractor_if #(.WIDTH(4)) if4 ();

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (if8.slave)
   );

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (if4.slave)
   );

   // Free-running 10 ns clock.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation with latency, busy and result checks.
   task automatic apply_stimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                                 input logic bi, input logic [7:0] ed, input logic eb);
      int lat;
      if8.start_i  = 1'b1;
      if8.a_i      = a;
      if8.b_i      = b;
      if8.borrow_i = bi;
      @(posedge clk_i); #1;
      if8.start_i  = 1'b0;
      if8.a_i      = ~a;
      if8.b_i      = ~b;
      if8.borrow_i = ~bi;
      check_output({tag, "_busy_e0"}, 32'(if8.busy_o), 32'd1);
      lat = 0;
      while (!if8.done_o && lat < 20) begin
         @(posedge clk_i); #1;
         lat++;
         if (!if8.done_o) check_output({tag, "_busy_run"}, 32'(if8.busy_o), 32'd1);
      end
      check_output({tag, "_latency"}, 32'(lat), 32'd8);
      check_output({tag, "_busy_done"}, 32'(if8.busy_o), 32'd0);
      check_output({tag, "_diff"}, 32'(if8.diff_o), 32'(ed));
      check_output({tag, "_borrow"}, 32'(if8.borrow_o), 32'(eb));
      @(posedge clk_i); #1;
      check_output({tag, "_done_fall"}, 32'(if8.done_o), 32'd0);
      check_output({tag, "_diff_hold"}, 32'(if8.diff_o), 32'(ed));
   endtask

   initial begin
      int         lat;
      int         gap;
      int         pulses;
      logic [4:0] model;

      checks       = 0;
      errors       = 0;
      rst_n_i      = 1'b0;
      if8.start_i  = 1'b0;
      if8.a_i      = '0;
      if8.b_i      = '0;
      if8.borrow_i = 1'b0;
      if4.start_i  = 1'b0;
      if4.a_i      = '0;
      if4.b_i      = '0;
      if4.borrow_i = 1'b0;

      $display("[TB] reset state");
      repeat (2) @(posedge clk_i);
      #1;
      check_output("rst_busy", 32'(if8.busy_o), 32'd0);
      check_output("rst_done", 32'(if8.done_o), 32'd0);
      check_output("rst_diff", 32'(if8.diff_o), 32'd0);
      check_output("rst_borrow", 32'(if8.borrow_o), 32'd0);
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      $display("[TB] directed 8-bit vectors");
      apply_stimulus("5A_3C", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
      apply_stimulus("00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
      apply_stimulus("80_80_b", 8'h80, 8'h80, 1'b1, 8'hFF, 1'b1);

      $display("[TB] start during run, then held through done");
      if8.start_i  = 1'b1;
      if8.a_i      = 8'h33;
      if8.b_i      = 8'h11;
      if8.borrow_i = 1'b0;
      @(posedge clk_i); #1;
      if8.start_i  = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      if8.start_i  = 1'b1;
      if8.a_i      = 8'hF0;
      if8.b_i      = 8'h0F;
      if8.borrow_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      check_output("b2b_busy_e7", 32'(if8.busy_o), 32'd1);
      check_output("b2b_done_e7", 32'(if8.done_o), 32'd0);
      @(posedge clk_i); #1;
      check_output("b2b_done1", 32'(if8.done_o), 32'd1);
      check_output("b2b_diff1", 32'(if8.diff_o), 32'h22);
      check_output("b2b_borrow1", 32'(if8.borrow_o), 32'd0);
      @(posedge clk_i); #1;
      if8.start_i = 1'b0;
      check_output("b2b_busy_e9", 32'(if8.busy_o), 32'd1);
      check_output("b2b_done_e9", 32'(if8.done_o), 32'd0);
      check_output("b2b_diff_hold", 32'(if8.diff_o), 32'h22);
      gap = 1;
      while (!if8.done_o && gap < 20) begin
         @(posedge clk_i); #1;
         gap++;
      end
      check_output("b2b_gap", 32'(gap), 32'd9);
      check_output("b2b_diff2", 32'(if8.diff_o), 32'hE1);
      check_output("b2b_borrow2", 32'(if8.borrow_o), 32'd0);
      @(posedge clk_i); #1;

      $display("[TB] asynchronous reset during run");
      if8.start_i  = 1'b1;
      if8.a_i      = 8'h77;
      if8.b_i      = 8'h22;
      if8.borrow_i = 1'b0;
      @(posedge clk_i); #1;
      if8.start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #3;
      rst_n_i = 1'b0;
      #1;
      check_output("mid_rst_busy", 32'(if8.busy_o), 32'd0);
      check_output("mid_rst_done", 32'(if8.done_o), 32'd0);
      check_output("mid_rst_diff", 32'(if8.diff_o), 32'd0);
      check_output("mid_rst_borrow", 32'(if8.borrow_o), 32'd0);
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk_i); #1;
         if (if8.done_o || if8.busy_o) pulses++;
      end
      check_output("mid_rst_quiet", 32'(pulses), 32'd0);
      apply_stimulus("10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

      $display("[TB] exhaustive 4-bit sweep");
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int bi = 0; bi < 2; bi++) begin
               model        = {1'b0, 4'(a)} - {1'b0, 4'(b)} - 5'(bi);
               if4.start_i  = 1'b1;
               if4.a_i      = 4'(a);
               if4.b_i      = 4'(b);
               if4.borrow_i = 1'(bi);
               @(posedge clk_i); #1;
               if4.start_i = 1'b0;
               lat = 0;
               while (!if4.done_o && lat < 12) begin
                  @(posedge clk_i); #1;
                  lat++;
               end
               check_output($sformatf("w4_lat_%0h_%0h_%0d", a, b, bi), 32'(lat), 32'd4);
               check_output($sformatf("w4_diff_%0h_%0h_%0d", a, b, bi), 32'(if4.diff_o), 32'(model[3:0]));
               check_output($sformatf("w4_borrow_%0h_%0h_%0d", a, b, bi), 32'(if4.borrow_o), 32'(model[4]));
               @(posedge clk_i); #1;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial multi-bit subtractor built around the team's existing 1-bit full subtractor, which it instantiates (ports a_i, b_i, c_i, borrow_o, diff_o). It is the sequencing stage directly upstream of that cell. It latches two WIDTH-bit operands, feeds them LSB-first into the cell one bit per clock, registers the borrow between bits, and collects the difference bits into a result word. It computes a - b - borrow_i in WIDTH cycles with a start/done handshake.

## Interface

- WIDTH, 8, operand and result width in bits; legal range 2..32.

- clk_i  in  1  single clock, rising-edge active.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- start_i  in  1  request a subtraction; sampled only while busy_o = 0.
- a_i  in  WIDTH  minuend; sampled on the accepting edge.
- b_i  in  WIDTH  subtrahend; sampled on the accepting edge.
- borrow_i  in  1  initial borrow into bit 0; sampled on the accepting edge.
- busy_o  out  1  high while bits are being processed.
- done_o  out  1  one-cycle pulse marking that diff_o/borrow_o have just been updated.
- diff_o  out  WIDTH  result (a_i - b_i - borrow_i) mod 2^WIDTH.
- borrow_o  out  1  final borrow out of the MSB; 1 exactly when a_i < b_i + borrow_i.

## Operation

- States: IDLE, RUN, DONE. The state register, operand shift registers, borrow register, bit counter and output registers are all reset asynchronously by rst_n_i = 0.
- Reset values: state IDLE, busy_o 0, done_o 0, diff_o 0, borrow_o 0, counter 0, internal borrow 0.
- IDLE or DONE with start_i = 1:
  - Load a_i into shift register A and b_i into shift register B.
  - Load borrow_i into the borrow register and clear the counter.
  - Go to RUN.
- IDLE or DONE with start_i = 0: go to or stay in IDLE.
- RUN, each edge:
  - The cell inputs are a = A[0], b = B[0], c = the borrow register.
  - The borrow register takes the cell's borrow_o.
  - A and B shift right by one bit.
  - The cell's diff_o shifts into the MSB of a work register, which also shifts right.
  - The counter increments.
- RUN, on the edge where the counter = WIDTH-1:
  - Perform the normal bit step.
  - Also load diff_o with the completed work word and load borrow_o with the final cell borrow.
  - Go to DONE.
- DONE lasts exactly one cycle: done_o = 1, busy_o = 0.
- Cell function, decided: diff = a ^ b ^ c; borrow = (~a & b) | (~a & c) | (b & c).
- start_i while in RUN is ignored; the operation in flight is unaffected.
- diff_o and borrow_o change only on the final RUN edge. They hold between operations, including through IDLE and during the RUN of a following operation.
- a_i, b_i and borrow_i are don't-care except on the accepting edge.
- Reset asserted mid-RUN: all state returns to reset values immediately. The partial result is discarded and no done_o pulse occurs.

## Timing

- Accepting edge E0: busy_o = 0 and start_i = 1 at the rising edge.
- busy_o = 1 from after E0 through edge E(WIDTH).
- After E(WIDTH):
  - done_o = 1 and busy_o = 0.
  - diff_o and borrow_o are valid.
- Latency is WIDTH cycles from the accepting edge to done_o rising.
- done_o falls after E(WIDTH+1) unless a new operation is accepted on that edge. Even then it falls, because done_o is registered from the DONE state only.
- Back-to-back: start_i held high during DONE is accepted on E(WIDTH+1). Throughput is then one result every WIDTH+1 cycles.
- No combinational path from any input to any output; all outputs are registered.

## Test plan

- Reset: assert rst_n_i = 0 asynchronously mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- WIDTH=8, a_i=0x5A, b_i=0x3C, borrow_i=0, single start pulse:
  - busy_o is high for 8 cycles.
  - done_o pulses exactly 8 cycles after the accepting edge.
  - diff_o=0x1E, borrow_o=0.
- WIDTH=8, a_i=0x00, b_i=0x01, borrow_i=0 -> diff_o=0xFF, borrow_o=1.
- WIDTH=8, a_i=0x80, b_i=0x80, borrow_i=1 -> diff_o=0xFF, borrow_o=1.
- start_i pulsed mid-RUN with new operands -> ignored; the first result completes correctly.
  - start_i held high through DONE -> second operation accepted on the DONE edge.
  - The second done_o arrives 9 cycles after the first.
- rst_n_i pulsed low at the 4th RUN cycle -> returns to IDLE with outputs 0 and no done_o.
  - A following 0x10 - 0x01 -> diff_o=0x0F, borrow_o=0.
- WIDTH=4: all 512 combinations of a, b and borrow_i are compared against a reference model of (a - b - borrow_i), including both borrow_o values.
